// File: rtl/qam_pkg.sv
// Shared types and helpers for the adaptive QAM mapper: constellation mode
// enumeration, bits-per-symbol lookup and clamping of the requested mode.
package qam_pkg;

  typedef enum logic [1:0] {QAM4, QAM16, QAM64, QAM256} qam_mode_e;

  function automatic int unsigned bits_per_sym(input qam_mode_e m);
    return 2 * (int'(m) + 1);
  endfunction

  // Requests above the largest built constellation fall back to that constellation.
  function automatic qam_mode_e clamp_mode(input logic [1:0] m, input int max_order);
    qam_mode_e top;
    top = (max_order <= 4)  ? QAM4  :
          (max_order <= 16) ? QAM16 :
          (max_order <= 64) ? QAM64 : QAM256;
    return (m > top) ? top : qam_mode_e'(m);
  endfunction

endpackage

// File: rtl/qam_mapper_adaptive_if.sv
// Input word stream and output symbol stream of the mapper, with the mode select.
interface qam_mapper_adaptive_if #(
  parameter int DATA_WIDTH = 8,
  parameter int AMP_W      = 5
);
  logic [1:0]              i_mode;
  logic [DATA_WIDTH-1:0]   i_data;
  logic                    i_dv;
  logic                    i_last;
  logic                    i_ready;
  logic signed [AMP_W-1:0] o_i;
  logic signed [AMP_W-1:0] o_q;
  logic                    o_dv;
  logic                    o_last;
  logic                    o_ready;

  modport master (output i_mode, i_data, i_dv, i_last, o_ready,
                  input  i_ready, o_i, o_q, o_dv, o_last);
  modport slave  (input  i_mode, i_data, i_dv, i_last, o_ready,
                  output i_ready, o_i, o_q, o_dv, o_last);
endinterface

// File: rtl/qam_axis_map.sv
// One constellation axis: Gray code -> binary -> signed odd level 2b-(L-1).
// lmax = L-1 is an all-ones mask over the active low bits of g.
module qam_axis_map #(
  parameter int H = 4
) (
  input  logic [H-1:0]      g,
  input  logic [H-1:0]      lmax,
  output logic signed [H:0] level
);
  logic [H-1:0]        b;
  logic signed [H+1:0] wide;

  always_comb begin
    b = '0;
    b[H-1] = g[H-1];
    for (int j = H - 2; j >= 0; j--) b[j] = b[j+1] ^ g[j];
    wide  = signed'({1'b0, b, 1'b0}) - signed'({2'b00, lmax});
    level = wide[H:0];
  end
endmodule

// File: rtl/qam_mapper_adaptive.sv
// Streaming QAM mapper: bit gearbox packing DATA_WIDTH-bit words into k-bit
// symbols (k set per burst), Gray-to-level mapping per axis, one output register.
module qam_mapper_adaptive
  import qam_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_ORDER  = 256,
  parameter int MAX_BITS   = $clog2(MAX_ORDER),
  parameter int AMP_W      = MAX_BITS / 2 + 1
) (
  input logic                 clk,
  input logic                 rst,
  qam_mapper_adaptive_if.slave bus
);
  localparam int ACC_W  = DATA_WIDTH + MAX_BITS;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int H      = MAX_BITS / 2;
  localparam logic [FILL_W-1:0] MAXB = FILL_W'(MAX_BITS);
  localparam logic [FILL_W-1:0] HB   = FILL_W'(H);
  localparam logic [FILL_W-1:0] DWB  = FILL_W'(DATA_WIDTH);

  logic [ACC_W-1:0]    acc, acc_sh, acc_n, word_ext;
  logic [FILL_W-1:0]   fill, fill_sh, fill_n, k, h;
  qam_mode_e           mode_q;
  logic                last_pending, ready_en;
  logic                can_load, take, flush, accept;
  logic [MAX_BITS-1:0] sym;
  logic [H-1:0]        lmax, i_g, q_g;
  logic signed [H:0]   lvl_i, lvl_q;

  assign k        = FILL_W'(bits_per_sym(mode_q));
  assign h        = k >> 1;
  assign can_load = !bus.o_dv || bus.o_ready;
  assign take     = can_load && (fill >= k);
  assign flush    = can_load && last_pending && (fill != '0) && (fill < k);
  assign accept   = bus.i_dv && bus.i_ready;
  assign bus.i_ready = ready_en && (fill <= MAXB) && !last_pending;

  // Top k bits of the MSB-aligned accumulator; bits below fill are always zero,
  // so a flush symbol comes out zero-padded without extra logic.
  assign sym  = acc[ACC_W-1 -: MAX_BITS] >> (MAXB - k);
  assign lmax = {H{1'b1}} >> (HB - h);
  assign i_g  = H'(sym >> h);
  assign q_g  = H'(sym) & lmax;

  qam_axis_map #(.H(H)) u_map_i (.g(i_g), .lmax(lmax), .level(lvl_i));
  qam_axis_map #(.H(H)) u_map_q (.g(q_g), .lmax(lmax), .level(lvl_q));

  always_comb begin
    acc_sh   = take ? (acc << k) : (flush ? '0 : acc);
    fill_sh  = take ? (fill - k) : (flush ? '0 : fill);
    word_ext = {bus.i_data, {MAX_BITS{1'b0}}} >> fill_sh;
    acc_n    = accept ? (acc_sh | word_ext) : acc_sh;
    fill_n   = accept ? (fill_sh + DWB) : fill_sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      fill         <= '0;
      mode_q       <= QAM4;
      last_pending <= 1'b0;
      ready_en     <= 1'b0;
    end else begin
      acc      <= acc_n;
      fill     <= fill_n;
      ready_en <= 1'b1;
      if (accept && fill == '0 && !last_pending)
        mode_q <= clamp_mode(bus.i_mode, MAX_ORDER);
      if (bus.o_dv && bus.o_ready && bus.o_last)
        last_pending <= 1'b0;
      if (accept && bus.i_last)
        last_pending <= 1'b1;
    end
  end

  // Output register: loads a new symbol whenever it is empty or draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.o_i    <= '0;
      bus.o_q    <= '0;
      bus.o_dv   <= 1'b0;
      bus.o_last <= 1'b0;
    end else if (take || flush) begin
      bus.o_i    <= AMP_W'(lvl_i);
      bus.o_q    <= AMP_W'(lvl_q);
      bus.o_dv   <= 1'b1;
      bus.o_last <= flush || (last_pending && fill == k);
    end else if (bus.o_ready) begin
      bus.o_dv   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_qam_mapper_adaptive.sv
// Directed bench for qam_mapper_adaptive with a bit-level reference model
// feeding an expected-symbol queue.
module tb_qam_mapper_adaptive;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qam_mapper_adaptive_if #(.DATA_WIDTH(8), .AMP_W(5)) bus ();
  qam_mapper_adaptive #(.DATA_WIDTH(8), .MAX_ORDER(256)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total  = 0;
  int passed = 0;
  logic [10:0] exp_q[$];
  bit          bits[$];
  int          tmode;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int level_of(input logic [7:0] g, input int h);
    bit x = 1'b0;
    int b = 0;
    for (int j = h - 1; j >= 0; j--) begin
      x = x ^ g[j];
      b = b * 2 + int'(x);
    end
    return 2 * b - ((1 << h) - 1);
  endfunction

  function automatic logic [10:0] ref_map(input int k, input logic [7:0] s, input bit last);
    int h, li, lq;
    logic [7:0] gi, gq;
    h  = k / 2;
    gi = s >> h;
    gq = s & 8'((1 << h) - 1);
    li = level_of(gi, h);
    lq = level_of(gq, h);
    return {5'(li), 5'(lq), last};
  endfunction

  task automatic model_word(input logic [7:0] w, input bit last);
    int k;
    logic [7:0] s;
    k = 2 * (tmode + 1);
    for (int j = 7; j >= 0; j--) bits.push_back(w[j]);
    while (bits.size() >= k) begin
      s = '0;
      for (int j = 0; j < k; j++) s = {s[6:0], bits.pop_front()};
      exp_q.push_back(ref_map(k, s, last && bits.size() == 0));
    end
    if (last && bits.size() > 0) begin
      s = '0;
      for (int j = 0; j < k; j++) s = {s[6:0], (bits.size() > 0) ? bits.pop_front() : 1'b0};
      exp_q.push_back(ref_map(k, s, 1'b1));
    end
  endtask

  task automatic cycle(output bit acc);
    logic [10:0] e;
    @(negedge clk);
    acc = bus.i_dv && bus.i_ready;
    if (bus.o_dv && bus.o_ready) begin
      if (exp_q.size() == 0) check("extra_sym", {bus.o_i, bus.o_q, bus.o_last}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("sym", {bus.o_i, bus.o_q, bus.o_last}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input logic [7:0] w, input bit last);
    bit a = 1'b0;
    for (int n = 0; n < 50 && !a; n++) cycle(a);
    if (a) model_word(w, last);
    else check("accept_timeout", 0, 1);
    bus.i_dv = 1'b0;
    bus.i_last = 1'b0;
  endtask

  task automatic send(input logic [7:0] w, input bit last);
    bus.i_data = w;
    bus.i_last = last;
    bus.i_dv   = 1'b1;
    wait_accept(w, last);
  endtask

  task automatic drain();
    bit a;
    for (int n = 0; n < 100 && exp_q.size() > 0; n++) cycle(a);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    bit a;
    logic [10:0] held;
    rst = 1'b1;
    bus.i_mode = 2'd0; bus.i_data = '0; bus.i_dv = 1'b0; bus.i_last = 1'b0; bus.o_ready = 1'b1;
    #12;
    check("rst_o_dv", bus.o_dv, 0);
    check("rst_o_last", bus.o_last, 0);
    check("rst_o_iq", {bus.o_i, bus.o_q}, 0);
    check("rst_i_ready", bus.i_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", bus.i_ready, 1);

    // QPSK, four symbols from one word
    tmode = 0; bus.i_mode = 2'd0;
    send(8'b1011_0001, 1'b1);
    drain();

    // 16-QAM with latency check
    tmode = 1; bus.i_mode = 2'd1;
    send(8'b1110_0000, 1'b1);
    check("lat16_dv_accept_edge", bus.o_dv, 0);
    cycle(a);
    check("lat16_dv_next_edge", bus.o_dv, 1);
    drain();

    // 256-QAM extremes
    tmode = 3; bus.i_mode = 2'd3;
    send(8'hFF, 1'b1);
    drain();
    send(8'h00, 1'b1);
    drain();

    // 64-QAM with a zero-padded flush symbol
    tmode = 2; bus.i_mode = 2'd2;
    send(8'hFC, 1'b1);
    check("flush_ready_low", bus.i_ready, 0);
    drain();
    check("ready_after_flush", bus.i_ready, 1);

    // 64-QAM under backpressure
    bus.o_ready = 1'b0;
    send(8'hA5, 1'b0);
    send(8'h3C, 1'b0);
    bus.i_data = 8'h96; bus.i_last = 1'b1; bus.i_dv = 1'b1;
    held = {bus.o_i, bus.o_q, bus.o_last};
    check("bp_head", held, exp_q[0]);
    for (int n = 0; n < 6; n++) begin
      cycle(a);
      check("bp_no_accept", a, 0);
      check("bp_dv", bus.o_dv, 1);
      check("bp_hold", {bus.o_i, bus.o_q, bus.o_last}, held);
    end
    bus.o_ready = 1'b1;
    wait_accept(8'h96, 1'b1);
    drain();

    // reset in the middle of a burst
    bus.o_ready = 1'b0;
    send(8'hFF, 1'b0);
    cycle(a);
    check("pre_rst_dv", bus.o_dv, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_dv", bus.o_dv, 0);
    check("rst_mid_iq", {bus.o_i, bus.o_q}, 0);
    exp_q.delete();
    bits.delete();
    @(posedge clk); #1 rst = 1'b0;
    bus.o_ready = 1'b1;
    cycle(a);
    check("rst_mid_ready", bus.i_ready, 1);
    check("rst_mid_no_dv", bus.o_dv, 0);
    tmode = 0; bus.i_mode = 2'd0;
    send(8'h1E, 1'b1);
    drain();
    cycle(a);
    check("end_idle", bus.o_dv, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
